eth_rx_frame_ctrl: RTL and testbench

//  Frame-level controller between the Ethernet RX buffer (32-bit AXIS read side) and the uDMA RX channel.

---
 rtl/eth_rx_frame_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_ctrl.sv
// Frame sequencer from the RX buffer AXIS read side into the uDMA RX channel, with length limit and status.
// Define ETH_RX_CTRL_STATS_EN to build the frame/drop statistics counters.
module eth_rx_frame_ctrl #(
   parameter int unsigned LEN_W = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_en_i,
   input  logic [LEN_W-1:0] cfg_max_len_i,
   input  logic [31:0]      s_axis_tdata,
   input  logic [1:0]       s_axis_byte_count,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tuser,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   output logic [31:0]      udma_data_o,
   output logic [1:0]       udma_bytes_o,
   output logic             udma_valid_o,
   input  logic             udma_ready_i,
   output logic             busy_o,
   output logic             sts_valid_o,
   output logic [LEN_W-1:0] sts_len_o,
   output logic [2:0]       sts_err_o,
   output logic [CNT_W-1:0] sts_frame_cnt_o,
   output logic [CNT_W-1:0] sts_drop_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP, S_STATUS} state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [2:0]       err_q, err_d;
   logic [31:0]      udma_data_q, udma_data_d;
   logic [1:0]       udma_bytes_q, udma_bytes_d;
   logic             udma_valid_q, udma_valid_d;
   logic             busy_q, busy_d;
   logic             sts_valid_q, sts_valid_d;
   logic [LEN_W-1:0] sts_len_q, sts_len_d;
   logic [2:0]       sts_err_q, sts_err_d;

   logic             tready_c;
   logic             accept_c;
   logic [LEN_W:0]   len_sum_c;
   logic [LEN_W-1:0] len_next_c;
   logic             overlong_c;

   // Ready depends on the live uDMA ready so a full-rate stream needs no bubble.
   always_comb begin
      tready_c = 1'b0;
      if (state_q == S_FRAME) tready_c = ~udma_valid_q | udma_ready_i;
      else if (state_q == S_DROP) tready_c = 1'b1;
   end

   always_comb begin
      accept_c   = s_axis_tvalid & tready_c;
      len_sum_c  = {1'b0, len_q} + (LEN_W+1)'(s_axis_byte_count) + (LEN_W+1)'(1);
      len_next_c = len_sum_c[LEN_W] ? {LEN_W{1'b1}} : len_sum_c[LEN_W-1:0];
      overlong_c = (cfg_max_len_i != '0) && (len_next_c > cfg_max_len_i);
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      err_d        = err_q;
      udma_data_d  = udma_data_q;
      udma_bytes_d = udma_bytes_q;
      udma_valid_d = udma_valid_q & ~udma_ready_i;
      sts_len_d    = sts_len_q;
      sts_err_d    = sts_err_q;

      case (state_q)
         S_IDLE: begin
            len_d = '0;
            err_d = '0;
            if (cfg_en_i && s_axis_tvalid) state_d = S_FRAME;
         end
         S_FRAME: begin
            if (accept_c) begin
               len_d = len_next_c;
               if (overlong_c) begin
                  err_d[1] = 1'b1;
                  state_d  = s_axis_tlast ? S_STATUS : S_DROP;
               end else begin
                  udma_data_d  = s_axis_tdata;
                  udma_bytes_d = s_axis_byte_count;
                  udma_valid_d = 1'b1;
                  if (s_axis_tlast) begin
                     err_d[0] = s_axis_tuser;
                     state_d  = S_STATUS;
                  end else if (!cfg_en_i) begin
                     err_d[2] = 1'b1;
                     state_d  = S_DROP;
                  end
               end
            end else if (!cfg_en_i) begin
               err_d[2] = 1'b1;
               state_d  = S_DROP;
            end
         end
         S_DROP: begin
            if (accept_c) begin
               len_d = len_next_c;
               if (s_axis_tlast) begin
                  err_d[0] = err_q[0] | s_axis_tuser;
                  state_d  = S_STATUS;
               end
            end
         end
         S_STATUS: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Status registers are loaded on entry so they are visible during the STATUS cycle.
      sts_valid_d = (state_d == S_STATUS);
      if (sts_valid_d) begin
         sts_len_d = len_d;
         sts_err_d = err_d;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         err_q        <= '0;
         udma_data_q  <= '0;
         udma_bytes_q <= '0;
         udma_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         sts_valid_q  <= 1'b0;
         sts_len_q    <= '0;
         sts_err_q    <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         err_q        <= err_d;
         udma_data_q  <= udma_data_d;
         udma_bytes_q <= udma_bytes_d;
         udma_valid_q <= udma_valid_d;
         busy_q       <= busy_d;
         sts_valid_q  <= sts_valid_d;
         sts_len_q    <= sts_len_d;
         sts_err_q    <= sts_err_d;
      end
   end

`ifdef ETH_RX_CTRL_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Counters wrap naturally; they advance together with the status pulse.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (sts_valid_d) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
         if (err_d != 3'b000) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign sts_frame_cnt_o = frame_cnt_q;
   assign sts_drop_cnt_o  = drop_cnt_q;
`else
   assign sts_frame_cnt_o = '0;
   assign sts_drop_cnt_o  = '0;
`endif

   assign s_axis_tready = tready_c;
   assign udma_data_o   = udma_data_q;
   assign udma_bytes_o  = udma_bytes_q;
   assign udma_valid_o  = udma_valid_q;
   assign busy_o        = busy_q;
   assign sts_valid_o   = sts_valid_q;
   assign sts_len_o     = sts_len_q;
   assign sts_err_o     = sts_err_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed self-checking bench for eth_rx_frame_ctrl; expected values are hand-computed constants
// plus a small per-frame model of which beats reach uDMA.
module tb_eth_rx_frame_ctrl;

   localparam int unsigned LEN_W = 16;
   localparam int unsigned CNT_W = 16;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             cfg_en_i;
   logic [LEN_W-1:0] cfg_max_len_i;
   logic [31:0]      s_axis_tdata;
   logic [1:0]       s_axis_byte_count;
   logic             s_axis_tvalid;
   logic             s_axis_tuser;
   logic             s_axis_tlast;
   logic             s_axis_tready;
   logic [31:0]      udma_data_o;
   logic [1:0]       udma_bytes_o;
   logic             udma_valid_o;
   logic             udma_ready_i;
   logic             busy_o;
   logic             sts_valid_o;
   logic [LEN_W-1:0] sts_len_o;
   logic [2:0]       sts_err_o;
   logic [CNT_W-1:0] sts_frame_cnt_o;
   logic [CNT_W-1:0] sts_drop_cnt_o;

   eth_rx_frame_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .cfg_en_i          (cfg_en_i),
      .cfg_max_len_i     (cfg_max_len_i),
      .s_axis_tdata      (s_axis_tdata),
      .s_axis_byte_count (s_axis_byte_count),
      .s_axis_tvalid     (s_axis_tvalid),
      .s_axis_tuser      (s_axis_tuser),
      .s_axis_tlast      (s_axis_tlast),
      .s_axis_tready     (s_axis_tready),
      .udma_data_o       (udma_data_o),
      .udma_bytes_o      (udma_bytes_o),
      .udma_valid_o      (udma_valid_o),
      .udma_ready_i      (udma_ready_i),
      .busy_o            (busy_o),
      .sts_valid_o       (sts_valid_o),
      .sts_len_o         (sts_len_o),
      .sts_err_o         (sts_err_o),
      .sts_frame_cnt_o   (sts_frame_cnt_o),
      .sts_drop_cnt_o    (sts_drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   int          sts_cnt = 0;
   int          stall_seen = 0;
   int          stall_viol = 0;
   bit          toggle_en = 1'b0;
   bit          hold_pending = 1'b0;
   logic [33:0] hold_val;
   logic [33:0] rx_q[$];
   logic [33:0] exp_q[$];

   // Observe the uDMA side mid-cycle, when inputs and outputs are settled for the coming edge.
   always @(negedge clk_i) begin
      #2;
      if (rst_i) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending && (!udma_valid_o || {udma_bytes_o, udma_data_o} !== hold_val))
            stall_viol++;
         if (udma_valid_o && !udma_ready_i) begin
            hold_pending = 1'b1;
            hold_val     = {udma_bytes_o, udma_data_o};
            stall_seen++;
         end else begin
            hold_pending = 1'b0;
         end
         if (udma_valid_o && udma_ready_i) rx_q.push_back({udma_bytes_o, udma_data_o});
         if (sts_valid_o) sts_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      if (toggle_en) udma_ready_i = ~udma_ready_i;
   endtask

   // Drives one frame; the model queues every beat expected on uDMA.
   task automatic send_frame(input int fid, input int n, input logic [1:0] last_bc,
                             input logic last_user, input int abort_at, input int max_len);
      int  len = 0;
      int  len_n;
      bit  drop = 1'b0;
      bit  acc;
      logic [1:0]  bc;
      logic [31:0] d;
      cfg_max_len_i = LEN_W'(max_len);
      for (int i = 0; i < n; i++) begin
         if (i == abort_at) begin
            s_axis_tvalid = 1'b0;
            cfg_en_i      = 1'b0;
            tick();
            drop = 1'b1;
         end
         bc = (i == n - 1) ? last_bc : 2'd3;
         d  = {8'(fid), 8'(i), 16'hBE00 | 16'(i)};
         s_axis_tvalid     = 1'b1;
         s_axis_tdata      = d;
         s_axis_byte_count = bc;
         s_axis_tlast      = (i == n - 1);
         s_axis_tuser      = (i == n - 1) ? last_user : 1'b0;
         len_n = len + int'(bc) + 1;
         if (!drop) begin
            if (max_len != 0 && len_n > max_len) drop = 1'b1;
            else exp_q.push_back({bc, d});
         end
         len = len_n;
         acc = 1'b0;
         for (int t = 0; t < 100 && !acc; t++) begin
            #1;
            acc = s_axis_tready;
            tick();
         end
         if (!acc) check("beat_accept_timeout", 64'(acc), 64'(1));
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_sts(input string tag, input int target);
      for (int t = 0; t < 200 && sts_cnt < target; t++) tick();
      check(tag, 64'(sts_cnt >= target), 64'(1));
      for (int t = 0; t < 6; t++) tick();
   endtask

   task automatic compare_rx(input string tag);
      int n;
      check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_beat"}, 64'(rx_q[i]), 64'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_tready"},  64'(s_axis_tready), 64'(0));
      check({tag, "_uvalid"},  64'(udma_valid_o), 64'(0));
      check({tag, "_udata"},   64'({udma_bytes_o, udma_data_o}), 64'(0));
      check({tag, "_busy"},    64'(busy_o), 64'(0));
      check({tag, "_stsv"},    64'(sts_valid_o), 64'(0));
      check({tag, "_stslen"},  64'(sts_len_o), 64'(0));
      check({tag, "_stserr"},  64'(sts_err_o), 64'(0));
      check({tag, "_cnts"},    64'({sts_frame_cnt_o, sts_drop_cnt_o}), 64'(0));
   endtask

   initial begin
      int base;
      rst_i = 1'b1;
      cfg_en_i = 1'b0;
      cfg_max_len_i = '0;
      s_axis_tdata = '0;
      s_axis_byte_count = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tuser = 1'b0;
      s_axis_tlast = 1'b0;
      udma_ready_i = 1'b0;

      // Reset
      tick(); tick();
      check_idle_outputs("reset");
      rst_i = 1'b0;
      tick();
      check_idle_outputs("post_reset");

      // 16-word frame at full rate: 15*4 + 2 = 62 bytes
      cfg_en_i = 1'b1;
      udma_ready_i = 1'b1;
      base = sts_cnt;
      send_frame(2, 16, 2'd1, 1'b0, -1, 0);
      wait_sts("t2_sts_timeout", base + 1);
      check("t2_len", 64'(sts_len_o), 64'(62));
      check("t2_err", 64'(sts_err_o), 64'(3'b000));
      check("t2_pulses", 64'(sts_cnt - base), 64'(1));
      check("t2_busy", 64'(busy_o), 64'(0));
      compare_rx("t2");

      // Overlong: max 8, four 4-byte words -> two forwarded, length still 16
      base = sts_cnt;
      send_frame(3, 4, 2'd3, 1'b0, -1, 8);
      wait_sts("t3_sts_timeout", base + 1);
      check("t3_len", 64'(sts_len_o), 64'(16));
      check("t3_err", 64'(sts_err_o), 64'(3'b010));
      compare_rx("t3");

      // Abort by disable after two of five words; remaining 12 bytes still counted
      base = sts_cnt;
      send_frame(4, 5, 2'd3, 1'b0, 2, 0);
      wait_sts("t4_sts_timeout", base + 1);
      check("t4_len", 64'(sts_len_o), 64'(20));
      check("t4_err", 64'(sts_err_o), 64'(3'b100));
      check("t4_busy", 64'(busy_o), 64'(0));
      check("t4_pulses", 64'(sts_cnt - base), 64'(1));
      compare_rx("t4");
      cfg_en_i = 1'b1;

      // MAC error on tlast with uDMA ready toggling: 5*4 + 3 = 23 bytes
      base = sts_cnt;
      cfg_max_len_i = '0;
      udma_ready_i = 1'b0;
      toggle_en = 1'b1;
      send_frame(5, 6, 2'd2, 1'b1, -1, 0);
      wait_sts("t5_sts_timeout", base + 1);
      toggle_en = 1'b0;
      udma_ready_i = 1'b1;
      tick(); tick();
      check("t5_len", 64'(sts_len_o), 64'(23));
      check("t5_err", 64'(sts_err_o), 64'(3'b001));
      check("t5_stall_seen", 64'(stall_seen != 0), 64'(1));
      check("t5_stability", 64'(stall_viol), 64'(0));
      compare_rx("t5");

      // Fresh reset, then 3 good frames (one single-word) and one with tuser
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      check("t6_cnt_reset", 64'({sts_frame_cnt_o, sts_drop_cnt_o}), 64'(0));
      base = sts_cnt;
      send_frame(6, 3, 2'd3, 1'b0, -1, 0);
      wait_sts("t6a_sts_timeout", base + 1);
      check("t6a_len", 64'(sts_len_o), 64'(12));
      send_frame(7, 1, 2'd0, 1'b0, -1, 0);
      wait_sts("t6b_sts_timeout", base + 2);
      check("t6b_single_len", 64'(sts_len_o), 64'(1));
      check("t6b_single_err", 64'(sts_err_o), 64'(3'b000));
      send_frame(8, 2, 2'd2, 1'b0, -1, 0);
      wait_sts("t6c_sts_timeout", base + 3);
      check("t6c_len", 64'(sts_len_o), 64'(7));
      send_frame(9, 2, 2'd0, 1'b1, -1, 0);
      wait_sts("t6d_sts_timeout", base + 4);
      check("t6d_len", 64'(sts_len_o), 64'(5));
      check("t6d_err", 64'(sts_err_o), 64'(3'b001));
`ifdef ETH_RX_CTRL_STATS_EN
      check("t6_frame_cnt", 64'(sts_frame_cnt_o), 64'(4));
      check("t6_drop_cnt", 64'(sts_drop_cnt_o), 64'(1));
`else
      check("t6_frame_cnt", 64'(sts_frame_cnt_o), 64'(0));
      check("t6_drop_cnt", 64'(sts_drop_cnt_o), 64'(0));
`endif
      compare_rx("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
